// File: rtl/vga_capture.sv
// vga_capture: recovers active-area pixels and frame timing from a VGA stream.
// Optional VGA_CAPTURE_CRC_EN adds a per-frame CRC-16-CCITT of the active pixels.
module vga_capture #(
    parameter int C_bits_x     = 12,
    parameter int C_bits_y     = 11,
    parameter int C_data_delay = 1
) (
    input  logic                clk_pixel,
    input  logic                reset,
    input  logic [7:0]          vga_r,
    input  logic [7:0]          vga_g,
    input  logic [7:0]          vga_b,
    input  logic                vga_hsync,
    input  logic                vga_vsync,
    input  logic                vga_blank,
    output logic                pixel_valid,
    output logic [C_bits_x-1:0] pixel_x,
    output logic [C_bits_y-1:0] pixel_y,
    output logic [7:0]          pixel_r,
    output logic [7:0]          pixel_g,
    output logic [7:0]          pixel_b,
    output logic                frame_start,
    output logic [C_bits_x-1:0] meas_frame_x,
    output logic [C_bits_y-1:0] meas_frame_y,
    output logic [C_bits_x-1:0] meas_active_x,
    output logic [C_bits_y-1:0] meas_active_y,
    output logic                locked,
    output logic                timing_error
`ifdef VGA_CAPTURE_CRC_EN
    ,
    output logic [15:0]         frame_crc,
    output logic                frame_crc_valid
`endif
);

    localparam logic [C_bits_x-1:0] HMAX = '1;
    localparam logic [C_bits_x-1:0] HSAT = HMAX - 1'b1;
    localparam logic [C_bits_y-1:0] VMAX = '1;

    typedef enum logic [1:0] {
        S_SEARCH,
        S_MEASURE,
        S_VERIFY,
        S_LOCKED
    } state_t;

    typedef struct packed {
        logic [C_bits_x-1:0] fx;
        logic [C_bits_y-1:0] fy;
        logic [C_bits_x-1:0] ax;
        logic [C_bits_y-1:0] ay;
    } meas_t;

    logic                hs_q, hs_p_q, vs_q, vs_p_q, blank_p_q;
    logic                blank_d;
    logic                hs_rise, vs_rise, active, run_end;
    logic [C_bits_x-1:0] hcnt_q, hcnt_d, line_len_q, line_len_d;
    logic [C_bits_y-1:0] vcnt_q, vcnt_d;
    logic [C_bits_x-1:0] ax_q, ax_d, last_ax_q, last_ax_d;
    logic [C_bits_y-1:0] ay_q, ay_d;
    state_t              state_q, state_d;
    meas_t               cand, stored_q, meas_q;
    logic                cand_eq, sat_evt, store_en, meas_en, lost;
    logic                pix_valid_q, frame_start_q, error_q;
    logic [C_bits_x-1:0] pix_x_q;
    logic [C_bits_y-1:0] pix_y_q;
    logic [23:0]         pix_rgb_q;

    // blank_d lines up with the rgb pins, which trail blank by C_data_delay
    if (C_data_delay == 0) begin : g_nodly
        assign blank_d = vga_blank;
    end else begin : g_dly
        logic [C_data_delay-1:0] sr_q;
        always_ff @(posedge clk_pixel) begin
            if (reset) sr_q <= '1;
            else       sr_q <= C_data_delay'({sr_q, vga_blank});
        end
        assign blank_d = sr_q[C_data_delay-1];
    end

    assign hs_rise = hs_q & ~hs_p_q;
    assign vs_rise = vs_q & ~vs_p_q;
    assign active  = ~blank_d;
    assign run_end = blank_d & ~blank_p_q;
    assign sat_evt = (hcnt_q == HSAT) & ~hs_rise;

    always_comb begin
        hcnt_d     = hcnt_q;
        line_len_d = line_len_q;
        vcnt_d     = vcnt_q;
        ax_d       = ax_q;
        last_ax_d  = last_ax_q;
        ay_d       = ay_q;
        if (hs_rise) begin
            hcnt_d     = C_bits_x'(1);
            line_len_d = hcnt_q;
        end else if (hcnt_q != HMAX) begin
            hcnt_d = hcnt_q + 1'b1;
        end
        if (vs_rise)                       vcnt_d = '0;
        else if (hs_rise && vcnt_q != VMAX) vcnt_d = vcnt_q + 1'b1;
        if (hs_rise)     ax_d = '0;
        else if (active) ax_d = ax_q + 1'b1;
        if (run_end && ax_q != '0) last_ax_d = ax_q;
        if (vs_rise)      ay_d = '0;
        else if (run_end) ay_d = ay_q + 1'b1;
    end

    // a coincident hsync edge still belongs to the frame that is closing
    always_comb begin
        cand.fx = hs_rise ? hcnt_q : line_len_q;
        cand.fy = vcnt_q + C_bits_y'(hs_rise);
        cand.ax = last_ax_q;
        cand.ay = ay_q;
        cand_eq = (cand == stored_q);
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) state_q <= S_SEARCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sat_evt) begin
            state_d = S_SEARCH;
        end else if (vs_rise) begin
            case (state_q)
                S_SEARCH:  state_d = S_MEASURE;
                S_MEASURE: state_d = S_VERIFY;
                S_VERIFY:  state_d = cand_eq ? S_LOCKED : S_VERIFY;
                S_LOCKED:  state_d = cand_eq ? S_LOCKED : S_VERIFY;
                default:   state_d = S_SEARCH;
            endcase
        end
    end

    always_comb begin
        store_en = 1'b0;
        meas_en  = 1'b0;
        lost     = 1'b0;
        if (!sat_evt && vs_rise) begin
            case (state_q)
                S_MEASURE: store_en = 1'b1;
                S_VERIFY: begin
                    meas_en  = cand_eq;
                    store_en = ~cand_eq;
                end
                S_LOCKED: begin
                    store_en = ~cand_eq;
                    lost     = ~cand_eq;
                end
                default: ;
            endcase
        end
    end

    assign locked = (state_q == S_LOCKED);

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            hs_q          <= 1'b0;
            hs_p_q        <= 1'b0;
            vs_q          <= 1'b0;
            vs_p_q        <= 1'b0;
            blank_p_q     <= 1'b1;
            hcnt_q        <= '0;
            line_len_q    <= '0;
            vcnt_q        <= '0;
            ax_q          <= '0;
            last_ax_q     <= '0;
            ay_q          <= '0;
            stored_q      <= '0;
            meas_q        <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
            frame_start_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            hs_q          <= vga_hsync;
            hs_p_q        <= hs_q;
            vs_q          <= vga_vsync;
            vs_p_q        <= vs_q;
            blank_p_q     <= blank_d;
            hcnt_q        <= hcnt_d;
            line_len_q    <= line_len_d;
            vcnt_q        <= vcnt_d;
            ax_q          <= ax_d;
            last_ax_q     <= last_ax_d;
            ay_q          <= ay_d;
            if (store_en) stored_q <= cand;
            if (meas_en)  meas_q   <= cand;
            pix_valid_q   <= active & locked;
            if (active) begin
                pix_x_q   <= ax_q;
                pix_y_q   <= ay_q;
                pix_rgb_q <= {vga_r, vga_g, vga_b};
            end
            frame_start_q <= vs_rise;
            error_q       <= sat_evt | lost;
        end
    end

    assign pixel_valid   = pix_valid_q;
    assign pixel_x       = pix_x_q;
    assign pixel_y       = pix_y_q;
    assign pixel_r       = pix_rgb_q[23:16];
    assign pixel_g       = pix_rgb_q[15:8];
    assign pixel_b       = pix_rgb_q[7:0];
    assign frame_start   = frame_start_q;
    assign timing_error  = error_q;
    assign meas_frame_x  = meas_q.fx;
    assign meas_frame_y  = meas_q.fy;
    assign meas_active_x = meas_q.ax;
    assign meas_active_y = meas_q.ay;

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc_q, fcrc_q;
    logic        fcrc_v_q;

    function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            crc_q    <= 16'hFFFF;
            fcrc_q   <= '0;
            fcrc_v_q <= 1'b0;
        end else begin
            if (vs_rise)     crc_q <= 16'hFFFF;
            else if (active) crc_q <= crc24(crc_q, {vga_r, vga_g, vga_b});
            if (vs_rise && locked) fcrc_q <= crc_q;
            fcrc_v_q <= vs_rise & locked;
        end
    end

    assign frame_crc       = fcrc_q;
    assign frame_crc_valid = fcrc_v_q;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: randomized small-geometry VGA frames against a frame-level model.
// Covers lock, pixel data/coordinates, timing change, hsync loss and mid-line reset.
module tb_vga_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, vga_blank;
    logic        pixel_valid;
    logic [11:0] pixel_x;
    logic [10:0] pixel_y;
    logic [7:0]  pixel_r, pixel_g, pixel_b;
    logic        frame_start;
    logic [11:0] meas_frame_x, meas_active_x;
    logic [10:0] meas_frame_y, meas_active_y;
    logic        locked, timing_error;
`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] frame_crc;
    logic        frame_crc_valid;
    int          ref_crc;
`endif

    int checks = 0;
    int errors = 0;
    int HT, VT, AW, AH, HT1;
    int pv_count = 0, te_count = 0, fs_count = 0, te0;
    logic [23:0] exp_rgb [0:63][0:63];

    always #5 clk = ~clk;

    vga_capture #(.C_bits_x(12), .C_bits_y(11), .C_data_delay(1)) dut (
        .clk_pixel(clk), .reset(reset),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank),
        .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
        .frame_start(frame_start),
        .meas_frame_x(meas_frame_x), .meas_frame_y(meas_frame_y),
        .meas_active_x(meas_active_x), .meas_active_y(meas_active_y),
        .locked(locked), .timing_error(timing_error)
`ifdef VGA_CAPTURE_CRC_EN
        , .frame_crc(frame_crc), .frame_crc_valid(frame_crc_valid)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

`ifdef VGA_CAPTURE_CRC_EN
    function automatic int crc_ref(input int crc, input int data);
        int c;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            c = c ^ (((data >> i) & 1) << 15);
            if ((c & 'h8000) != 0) c = ((c << 1) ^ 'h1021) & 'hFFFF;
            else                   c = (c << 1) & 'hFFFF;
        end
        return c;
    endfunction
`endif

    always @(negedge clk) begin
        if (timing_error) te_count++;
        if (frame_start)  fs_count++;
        if (pixel_valid) begin
            pv_count++;
            checks++;
            assert (int'(pixel_x) < AW && int'(pixel_y) < AH) else begin
                errors++;
                $error("FAIL pix_xy: observed x=%0d y=%0d expected below %0d/%0d",
                       pixel_x, pixel_y, AW, AH);
            end
            if (int'(pixel_x) < AW && int'(pixel_y) < AH)
                check("pix_rgb", int'({pixel_r, pixel_g, pixel_b}),
                      int'(exp_rgb[pixel_y][pixel_x]));
        end
    end

    // one frame; lines 0..AH-1 active, vsync on lines AH+1..AH+2
    task automatic run_frame(input int rst_v);
        logic [23:0] prev_pix, cur;
        bit          prev_act, act;
        prev_pix = '0;
        prev_act = 1'b0;
`ifdef VGA_CAPTURE_CRC_EN
        ref_crc = 'hFFFF;
`endif
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                @(negedge clk);
                reset     = (v == rst_v && h == HT / 2);
                act       = (h < AW && v < AH);
                vga_blank = !act;
                vga_hsync = (h >= AW + 2 && h < AW + 5);
                vga_vsync = (v >= AH + 1 && v < AH + 3);
                if (prev_act) begin
                    {vga_r, vga_g, vga_b} = prev_pix;
`ifdef VGA_CAPTURE_CRC_EN
                    ref_crc = crc_ref(ref_crc, int'(prev_pix));
`endif
                end else begin
                    {vga_r, vga_g, vga_b} = 24'($urandom);
                end
                cur = 24'($urandom);
                if (act) exp_rgb[v][h] = cur;
                prev_act = act;
                prev_pix = cur;
                if (reset) begin
                    @(posedge clk);
                    #1;
                    check("rst_pixel_valid", int'(pixel_valid), 0);
                    check("rst_locked", int'(locked), 0);
                    check("rst_timing_error", int'(timing_error), 0);
                    check("rst_meas_frame_x", int'(meas_frame_x), 0);
                    check("rst_pixel_x", int'(pixel_x), 0);
                    check("rst_pixel_rgb", int'({pixel_r, pixel_g, pixel_b}), 0);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vga_hsync = 1'b0;
            vga_vsync = 1'b0;
            vga_blank = 1'b1;
            {vga_r, vga_g, vga_b} = 24'($urandom);
        end
    endtask

    task automatic check_meas(input string tag);
        check({tag, "_frame_x"}, int'(meas_frame_x), HT);
        check({tag, "_frame_y"}, int'(meas_frame_y), VT);
        check({tag, "_active_x"}, int'(meas_active_x), AW);
        check({tag, "_active_y"}, int'(meas_active_y), AH);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        vga_hsync = 1'b0;
        vga_vsync = 1'b0;
        vga_blank = 1'b1;
        {vga_r, vga_g, vga_b} = '0;
        AW = $urandom_range(20, 8);
        HT = AW + $urandom_range(16, 8);
        AH = $urandom_range(8, 3);
        VT = AH + $urandom_range(8, 5);
        repeat (3) @(posedge clk);
        #1;
        check("reset_pixel_valid", int'(pixel_valid), 0);
        check("reset_locked", int'(locked), 0);
        check("reset_timing_error", int'(timing_error), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_pixel_xy", int'(pixel_x) + int'(pixel_y), 0);
        check_meas_zero: begin
            check("reset_meas_fx", int'(meas_frame_x), 0);
            check("reset_meas_fy", int'(meas_frame_y), 0);
            check("reset_meas_ax", int'(meas_active_x), 0);
            check("reset_meas_ay", int'(meas_active_y), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        te_count = 0;
        fs_count = 0;

        // lock needs three vsync rises after reset
        run_frame(-1);
        check("lock_after_1", int'(locked), 0);
        run_frame(-1);
        check("lock_after_2", int'(locked), 0);
        run_frame(-1);
        check("lock_after_3", int'(locked), 1);
        check_meas("lock1");
        check("no_error_clean", te_count, 0);
        check("frame_starts", fs_count, 3);

        pv_count = 0;
        run_frame(-1);
        check("pixels_per_frame", pv_count, AW * AH);
`ifdef VGA_CAPTURE_CRC_EN
        check("frame_crc_a", int'(frame_crc), ref_crc);
        run_frame(-1);
        check("frame_crc_b", int'(frame_crc), ref_crc);
`endif

        // line length change: one error, meas held, relock on next frame
        HT1 = HT;
        HT  = HT + 4;
        te0 = te_count;
        run_frame(-1);
        check("change_unlocked", int'(locked), 0);
        check("change_error_pulse", te_count - te0, 1);
        check("change_meas_held", int'(meas_frame_x), HT1);
        run_frame(-1);
        check("change_relocked", int'(locked), 1);
        check_meas("relock");

        // hsync lost long enough to saturate the line counter
        te0 = te_count;
        pv_count = 0;
        idle(4200);
        check("hold_error_pulse", te_count - te0, 1);
        check("hold_unlocked", int'(locked), 0);
        check("hold_no_pixels", pv_count, 0);
        pv_count = 0;
        run_frame(-1);
        run_frame(-1);
        check("search_lock_after_2", int'(locked), 0);
        check("search_no_pixels", pv_count, 0);
        run_frame(-1);
        check("search_lock_after_3", int'(locked), 1);
        check_meas("search");

        // one-clock reset mid-line
        run_frame(0);
        check("rst_lock_after_1", int'(locked), 0);
        run_frame(-1);
        check("rst_lock_after_2", int'(locked), 0);
        run_frame(-1);
        check("rst_lock_after_3", int'(locked), 1);
        check_meas("rst");
        pv_count = 0;
        run_frame(-1);
        check("rst_pixels_per_frame", pv_count, AW * AH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
